// File: rtl/doomsday_countdown.sv
// Doomsday Clock countdown stage: loads a minute value and counts down mm:ss at one tick per TICK_DIV clocks.
// Optional macro ALARM_BLINK_EN makes the alarm blink in EXPIRED instead of holding steady.
module doomsday_countdown #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] set_val_i,
   input  logic       load_i,
   input  logic       start_stop_i,
   output logic [7:0] minutes_o,
   output logic [5:0] seconds_o,
   output logic       running_o,
   output logic       expired_o,
   output logic       alarm_o
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_PAUSE   = 2'd2;
   localparam logic [1:0] S_EXPIRED = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [7:0]    minutes_q, minutes_d;
   logic [5:0]    seconds_q, seconds_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          alarm_q, alarm_d;

   logic          tick;
   logic [PW-1:0] presc_next;
   logic [7:0]    dec_min;
   logic [5:0]    dec_sec;
   logic          count_zero;

   assign tick       = (presc_q == TICK_LAST);
   assign presc_next = tick ? '0 : presc_q + PW'(1);
   assign count_zero = (minutes_q == 8'd0) && (seconds_q == 6'd0);

   // Borrow from minutes when seconds is already zero.
   always_comb begin
      dec_min = minutes_q;
      dec_sec = seconds_q - 6'd1;
      if (seconds_q == 6'd0) begin
         dec_min = minutes_q - 8'd1;
         dec_sec = 6'd59;
      end
   end

   always_comb begin
      state_d   = state_q;
      minutes_d = minutes_q;
      seconds_d = seconds_q;
      presc_d   = presc_q;
      case (state_q)
         S_IDLE: begin
            if (start_stop_i && !count_zero) begin
               state_d = S_RUN;
               presc_d = '0;
            end
         end
         S_RUN: begin
            presc_d = presc_next;
            if (tick) begin
               minutes_d = dec_min;
               seconds_d = dec_sec;
            end
            if (tick && dec_min == 8'd0 && dec_sec == 6'd0) begin
               state_d = S_EXPIRED;
            end else if (start_stop_i) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (start_stop_i) begin
               state_d = S_RUN;
            end
         end
         S_EXPIRED: begin
            if (start_stop_i) begin
               state_d = S_IDLE;
               presc_d = '0;
            end else begin
`ifdef ALARM_BLINK_EN
               presc_d = presc_next;
`else
               presc_d = '0;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A load outside RUN overrides whatever start_stop asked for.
      if (load_i && state_q != S_RUN) begin
         state_d   = S_IDLE;
         minutes_d = set_val_i;
         seconds_d = 6'd0;
         presc_d   = '0;
      end
   end

   always_comb begin
      alarm_d = 1'b0;
`ifdef ALARM_BLINK_EN
      if (state_d == S_EXPIRED) begin
         if (state_q != S_EXPIRED) begin
            alarm_d = 1'b1;
         end else begin
            alarm_d = tick ? ~alarm_q : alarm_q;
         end
      end
`else
      alarm_d = (state_d == S_EXPIRED);
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         minutes_q <= 8'd0;
         seconds_q <= 6'd0;
         presc_q   <= '0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         minutes_q <= minutes_d;
         seconds_q <= seconds_d;
         presc_q   <= presc_d;
         alarm_q   <= alarm_d;
      end
   end

   assign minutes_o = minutes_q;
   assign seconds_o = seconds_q;
   assign running_o = (state_q == S_RUN);
   assign expired_o = (state_q == S_EXPIRED);
   assign alarm_o   = alarm_q;

endmodule

// File: tb/tb_doomsday_countdown.sv
// Self-checking bench for doomsday_countdown with TICK_DIV=4, compared against a seconds-based reference model.
// Honors ALARM_BLINK_EN the same way the design does.
module tb_doomsday_countdown;

   localparam int TD = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

   logic       clk;
   logic       rst;
   logic [7:0] setVal;
   logic       load;
   logic       startStop;
   logic [7:0] minutesO;
   logic [5:0] secondsO;
   logic       runningO;
   logic       expiredO;
   logic       alarmO;

   int checks = 0;
   int errors = 0;

   // Reference model: remaining time in whole seconds plus RUN-cycle and EXPIRED-cycle counters.
   int mMode;
   int mTotal;
   int mRunCyc;
   int mExpCyc;

   doomsday_countdown #(.TICK_DIV(TD)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .set_val_i    (setVal),
      .load_i       (load),
      .start_stop_i (startStop),
      .minutes_o    (minutesO),
      .seconds_o    (secondsO),
      .running_o    (runningO),
      .expired_o    (expiredO),
      .alarm_o      (alarmO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [16:0] dutVec = {minutesO, secondsO, runningO, expiredO, alarmO};

   function automatic logic [16:0] modelVec();
      logic alm;
`ifdef ALARM_BLINK_EN
      alm = (mMode == M_EXP) && (((mExpCyc / TD) % 2) == 0);
`else
      alm = (mMode == M_EXP);
`endif
      return {8'(mTotal / 60), 6'(mTotal % 60), mMode == M_RUN, mMode == M_EXP, alm};
   endfunction

   task automatic resetModel();
      mMode = M_IDLE;
      mTotal = 0;
      mRunCyc = 0;
      mExpCyc = 0;
   endtask

   task automatic modelStep(input logic ld, input logic ss, input logic [7:0] sv);
      if (ld && mMode != M_RUN) begin
         mMode = M_IDLE;
         mTotal = int'(sv) * 60;
         mRunCyc = 0;
      end else begin
         case (mMode)
            M_IDLE: if (ss && mTotal != 0) begin mMode = M_RUN; mRunCyc = 0; end
            M_RUN: begin
               mRunCyc++;
               if (mRunCyc == TD) begin
                  mRunCyc = 0;
                  mTotal--;
                  if (mTotal == 0) begin mMode = M_EXP; mExpCyc = 0; end
               end
               if (mMode == M_RUN && ss) mMode = M_PAUSE;
            end
            M_PAUSE: if (ss) mMode = M_RUN;
            default: begin
               mExpCyc++;
               if (ss) mMode = M_IDLE;
            end
         endcase
      end
   endtask

   // One clock: drive on the falling edge, update the model at the rising edge, settle 1 time unit.
   task automatic applyStimulus(input logic ld, input logic ss, input logic [7:0] sv);
      @(negedge clk);
      load = ld;
      startStop = ss;
      setVal = sv;
      @(posedge clk);
      modelStep(ld, ss, sv);
      #1;
      load = 1'b0;
      startStop = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (dutVec !== 17'd0) begin
         errors++;
         $display("[TB] FAIL reset_async got=%h exp=%h", dutVec, 17'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      resetModel();
      applyStimulus(1'b0, 1'b0, 8'd0);
      checks++;
      if (dutVec !== 17'd0) begin
         errors++;
         $display("[TB] FAIL reset_idle got=%h exp=%h", dutVec, 17'd0);
      end
      applyStimulus(1'b1, 1'b0, 8'd3);
      checks++;
      if (dutVec !== {8'd3, 6'd0, 3'b000}) begin
         errors++;
         $display("[TB] FAIL load3 got=%h exp=%h", dutVec, {8'd3, 6'd0, 3'b000});
      end
   endtask

   task automatic test_count_borrow();
      applyStimulus(1'b1, 1'b0, 8'd1);
      applyStimulus(1'b0, 1'b1, 8'd0);
      for (int c = 1; c <= 240; c++) begin
         applyStimulus(1'b0, 1'b0, 8'd0);
         checks++;
         if (dutVec !== modelVec()) begin
            errors++;
            $display("[TB] FAIL count_cycle%0d got=%h exp=%h", c, dutVec, modelVec());
         end
         if (c == 4) begin
            checks++;
            if ({minutesO, secondsO} !== {8'd0, 6'd59}) begin
               errors++;
               $display("[TB] FAIL first_borrow got=%0d:%0d exp=0:59", minutesO, secondsO);
            end
         end
      end
      checks++;
      if ({minutesO, secondsO, runningO, expiredO} !== {8'd0, 6'd0, 2'b01}) begin
         errors++;
         $display("[TB] FAIL expiry_240 got=%0d:%0d run=%b exp=%b wanted 0:0 run=0 exp=1",
                  minutesO, secondsO, runningO, expiredO);
      end
   endtask

   task automatic test_ack();
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b0, 1'b0, 8'd0);
         checks++;
         if (dutVec !== modelVec()) begin
            errors++;
            $display("[TB] FAIL alarm_cycle%0d got=%h exp=%h", c, dutVec, modelVec());
         end
      end
      applyStimulus(1'b0, 1'b1, 8'd0);
      checks++;
      if (dutVec !== 17'd0) begin
         errors++;
         $display("[TB] FAIL acknowledge got=%h exp=%h", dutVec, 17'd0);
      end
   endtask

   task automatic test_pause_resume();
      applyStimulus(1'b1, 1'b0, 8'd2);
      applyStimulus(1'b0, 1'b1, 8'd0);
      applyStimulus(1'b0, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 8'd0);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b0, 1'b0, 8'd0);
         checks++;
         if ({minutesO, secondsO, runningO} !== {8'd2, 6'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL paused_hold%0d got=%0d:%0d run=%b exp=2:0 run=0", c, minutesO, secondsO, runningO);
         end
      end
      applyStimulus(1'b0, 1'b1, 8'd0);
      applyStimulus(1'b0, 1'b0, 8'd0);
      checks++;
      if ({minutesO, secondsO, runningO} !== {8'd2, 6'd0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL resume_plus1 got=%0d:%0d run=%b exp=2:0 run=1", minutesO, secondsO, runningO);
      end
      applyStimulus(1'b0, 1'b0, 8'd0);
      checks++;
      if ({minutesO, secondsO} !== {8'd1, 6'd59}) begin
         errors++;
         $display("[TB] FAIL resume_tick got=%0d:%0d exp=1:59", minutesO, secondsO);
      end
   endtask

   task automatic test_ignored_priority();
      applyStimulus(1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 8'd0);
      checks++;
      if (runningO !== 1'b0) begin
         errors++;
         $display("[TB] FAIL start_at_zero got=%b exp=0", runningO);
      end
      applyStimulus(1'b1, 1'b0, 8'd2);
      applyStimulus(1'b0, 1'b1, 8'd0);
      applyStimulus(1'b1, 1'b0, 8'd9);
      checks++;
      if ({minutesO, secondsO, runningO} !== {8'd2, 6'd0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL load_in_run got=%0d:%0d run=%b exp=2:0 run=1", minutesO, secondsO, runningO);
      end
      applyStimulus(1'b0, 1'b1, 8'd0);
      applyStimulus(1'b1, 1'b1, 8'd9);
      checks++;
      if ({minutesO, secondsO, runningO, expiredO} !== {8'd9, 6'd0, 2'b00}) begin
         errors++;
         $display("[TB] FAIL load_beats_start got=%0d:%0d run=%b exp=9:0 run=0", minutesO, secondsO, runningO);
      end
   endtask

   task automatic test_async_reset();
      applyStimulus(1'b1, 1'b0, 8'd2);
      applyStimulus(1'b0, 1'b1, 8'd0);
      for (int c = 0; c < 30 * TD; c++) applyStimulus(1'b0, 1'b0, 8'd0);
      checks++;
      if ({minutesO, secondsO, runningO} !== {8'd1, 6'd30, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reach_1_30 got=%0d:%0d run=%b exp=1:30 run=1", minutesO, secondsO, runningO);
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (dutVec !== 17'd0) begin
         errors++;
         $display("[TB] FAIL async_reset got=%h exp=%h", dutVec, 17'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      resetModel();
   endtask

   task automatic test_random();
      logic ld, ss;
      logic [7:0] sv;
      for (int c = 0; c < 3000; c++) begin
         ld = ($urandom_range(0, 199) == 0);
         ss = ($urandom_range(0, 24) == 0);
         sv = 8'($urandom_range(0, 2));
         applyStimulus(ld, ss, sv);
         checks++;
         if (dutVec !== modelVec()) begin
            errors++;
            $display("[TB] FAIL random_cycle%0d got=%h exp=%h", c, dutVec, modelVec());
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      load = 1'b0;
      startStop = 1'b0;
      setVal = 8'd0;
      resetModel();
      test_reset();
      test_count_borrow();
      test_ack();
      test_pause_resume();
      test_ignored_priority();
      test_async_reset();
      applyStimulus(1'b1, 1'b0, 8'd1);
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/doomsday_countdown.md
# doomsday_countdown

Countdown timer stage of the Doomsday Clock, sitting directly downstream of the push-button debouncer/press-counter stage. It captures the 8-bit minute value produced there and counts down in minutes:seconds at a 1 Hz rate derived from the system clock. It asserts an alarm when the count reaches 0:00. Start/stop and load commands arrive as single-cycle pulses from debounced buttons.

## Interface
- TICK_DIV, 100_000_000: clk cycles per one-second tick; legal range is ≥ 2. Benches use 4.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- set_val  in  8  minute value to load (press-count output of the upstream stage), 0–255
- load  in  1  single-cycle pulse: capture set_val
- start_stop  in  1  single-cycle pulse: start/pause/resume/acknowledge
- minutes  out  8  remaining minutes, registered
- seconds  out  6  remaining seconds, 0–59, registered
- running  out  1  high while in RUN
- expired  out  1  high while in EXPIRED
- alarm  out  1  alarm drive to the buzzer/LED

## Operation
- The state machine has four states: IDLE, RUN, PAUSE, EXPIRED. Reset enters IDLE.
- Reset values: minutes=0, seconds=0, running=0, expired=0, alarm=0, prescaler=0.
- load:
  - Accepted in IDLE, PAUSE and EXPIRED; ignored in RUN.
  - Effect: minutes←set_val, seconds←0, prescaler←0, next state IDLE. This clears expired and alarm.
- start_stop transitions:
  - IDLE → RUN only if {minutes,seconds}≠0; otherwise ignored. The prescaler is cleared on entry.
  - RUN → PAUSE. The prescaler holds its value.
  - PAUSE → RUN. Counting resumes from the held prescaler value.
  - EXPIRED → IDLE. The count stays 0:00 and the alarm clears.
- If load and start_stop are high in the same cycle, load wins and start_stop is dropped.
- Prescaler behaviour:
  - In RUN it counts 0..TICK_DIV-1 and wraps to 0.
  - A tick occurs in the cycle where prescaler==TICK_DIV-1.
- Decrement on tick:
  - If seconds>0: seconds−1.
  - Otherwise: seconds←59 and minutes−1.
  - minutes never underflows, because 0:00 exits RUN.
- If the decremented value is 0:00, the next state is EXPIRED, registered on the same edge as the count update.
- Outputs are decoded from the registered state: running=(RUN), expired=(EXPIRED). alarm is defined under Configuration.
- Arithmetic: minutes is unsigned 8-bit; seconds is unsigned 6-bit and never exceeds 59.

## Timing
- Latency from a load pulse at edge N: minutes/seconds show the new value after edge N; state is IDLE.
- Latency from start_stop at edge N: running=1 after edge N.
  - With the prescaler cleared on entry, the first tick edge is N+TICK_DIV.
  - A full tick period is exactly TICK_DIV cycles.
- Expiry: the count reads 0:00 and expired=1 after the same edge; running=0 from that edge.
- Pause/resume is cycle-exact. Total RUN cycles between ticks always equals TICK_DIV.
- Asynchronous reset mid-count: all outputs go to reset values immediately, with no wait for a clock edge. The state machine resumes in IDLE on the first edge after rst deasserts.
- Pulses longer than one cycle are treated as repeated commands. The upstream stage guarantees single-cycle pulses.

## Configuration
- ALARM_BLINK_EN:
  - Defined: in EXPIRED the prescaler keeps running. alarm is 1 on entry and toggles on every tick, giving a period of 2·TICK_DIV cycles.
  - Undefined: alarm is identical to expired (steady high) and the prescaler is held at 0 in EXPIRED.
- Either way, alarm=0 in every state other than EXPIRED.

## Test plan
- Reset/load:
  - Stimulus: assert rst, then release, then load with set_val=3.
  - Response: after reset all outputs are 0. After the load edge, minutes=3, seconds=0, running=0.
- Count and borrow (TICK_DIV=4):
  - Stimulus: load 1, then start_stop.
  - Response: 4 cycles later the count reads 0:59. After 59 further ticks it reads 0:00, expired=1, running=0. Total cycles from start: 240.
- Pause/resume:
  - Stimulus: load 2, start, pause 2 cycles after start, hold 10 cycles, resume.
  - Response: the first tick (→1:59) lands exactly 2 cycles after resume. No change occurs while paused.
- Ignored/priority commands:
  - start_stop with count 0:00 → stays IDLE.
  - load set_val=9 in RUN → count unaffected.
  - load and start_stop together in PAUSE → minutes=9, state IDLE, running=0.
- Acknowledge:
  - Stimulus: start_stop in EXPIRED.
  - Response: expired=0, alarm=0, state IDLE. With ALARM_BLINK_EN defined, alarm toggled every 4 cycles before the acknowledge.
- Async reset:
  - Stimulus: assert rst mid-cycle in RUN at count 1:30.
  - Response: outputs are 0 before the next clk edge.
